block_demux_reg: RTL



---
 rtl/block_demux_reg_pkg.sv | 22 ++
 rtl/block_demux_slot.sv | 46 ++++
 rtl/block_demux_reg.sv | 68 ++++++
 3 files changed

// File: rtl/block_demux_reg_pkg.sv
// Shared constants and helpers for the registered 1-to-N demultiplexer.
package block_demux_reg_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 2;
    localparam int POP_MAX   = 256;

    function automatic int num_dest(input int sel_w);
        return 1 << sel_w;
    endfunction

    // Callers zero-extend their valid vector to POP_MAX bits.
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/block_demux_slot.sv
// One-deep holding register for a single demux destination.
module block_demux_slot
    import block_demux_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_ack,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid_nxt
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // A load in the same cycle as an ack keeps the slot full with the new word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (i_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_valid_nxt = valid_d;

endmodule

// File: rtl/block_demux_reg.sv
// Registered 1-to-N demultiplexer: steers a selected word into per-destination slots.
module block_demux_reg
    import block_demux_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_valid,
    input  logic [SEL_W-1:0]                    i_sel,
    input  logic [WIDTH-1:0]                    i_data,
    output logic                                o_ready,
    output logic [num_dest(SEL_W)-1:0]          o_valid,
    output logic [num_dest(SEL_W)*WIDTH-1:0]    o_data,
    input  logic [num_dest(SEL_W)-1:0]          i_ack,
    output logic [SEL_W:0]                      o_occ
);

    localparam int N = num_dest(SEL_W);

    logic               accept;
    logic [N-1:0]       load;
    logic [N-1:0]       valid_nxt;
    logic [POP_MAX-1:0] pop_vec;
    logic [SEL_W:0]     occ_d, occ_q;

    // Ready looks only at the selected slot, so a full slot stalls just its own traffic.
    always_comb begin
        o_ready      = !o_valid[i_sel] || i_ack[i_sel];
        accept       = i_valid && o_ready;
        load         = '0;
        load[i_sel]  = accept;
    end

    for (genvar d = 0; d < N; d++) begin : g_slot
        block_demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_load      (load[d]),
            .i_ack       (i_ack[d]),
            .i_data      (i_data),
            .o_valid     (o_valid[d]),
            .o_data      (o_data[d*WIDTH +: WIDTH]),
            .o_valid_nxt (valid_nxt[d])
        );
    end

    // Occupancy is counted from the slots' next valid bits so it updates on the same edge.
    always_comb begin
        pop_vec        = '0;
        pop_vec[N-1:0] = valid_nxt;
        occ_d          = (SEL_W+1)'(popcount(pop_vec));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign o_occ = occ_q;

endmodule
